fetch_dispatch_queue: RTL and testbench

Circular instruction buffer between the fetch stage and the dispatch stage. Accepts up to `SUPERSCALAR_WAYS` fetched instructions per cycle and presents the oldest `SUPERSCALAR_WAYS` entries to dispatch as FETCH_DISPATCH_PACKETs. It consumes dispatch's DISPATCH_FETCH_PACKET stall feedback (`enable`, `first_stall_idx`) to retire exactly the dispatched prefix. It clears entirely on a branch flush.

---
 rtl/fetch_dispatch_queue.sv | 151 +++++++++++++++
 tb/tb_fetch_dispatch_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_dispatch_queue.sv
// fetch_dispatch_queue: circular instruction buffer between fetch and dispatch.
// Accepts up to SUPERSCALAR_WAYS instructions per cycle, compacting valid lanes
// into consecutive slots, and presents the oldest SUPERSCALAR_WAYS entries to
// dispatch. Dispatch stall feedback retires exactly the dispatched prefix, and a
// branch flush empties the queue.
//
// Packet layout (one lane, PKT_W = 3*XLEN+1 bits, lane i at [i*PKT_W +: PKT_W]):
//   {inst[XLEN-1:0], pc[XLEN-1:0], npc[XLEN-1:0], valid}
// dispatch_fetch_in layout: {enable, first_stall_idx[IDX_W-1:0]}
//
// Optional build macro FETCH_QUEUE_PERF_EN adds saturating performance counters
// stall_cycles, full_cycles and flush_count.
module fetch_dispatch_queue #(
  parameter int  SUPERSCALAR_WAYS = 3,
  parameter int  DEPTH            = 8,
  parameter int  CNT_BITS         = $clog2(DEPTH + 1),
  parameter int  XLEN             = 32,
  localparam int PKT_W            = 3 * XLEN + 1,
  localparam int IDX_W            = $clog2(SUPERSCALAR_WAYS + 1),
  localparam int PTR_W            = $clog2(DEPTH)
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              branch_flush_en,
  input  logic [SUPERSCALAR_WAYS*PKT_W-1:0] fetch_in,
  input  logic [IDX_W:0]                    dispatch_fetch_in,
  output logic                              fetch_ready,
  output logic [SUPERSCALAR_WAYS*PKT_W-1:0] dispatch_out,
  output logic [CNT_BITS-1:0]               count
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]                       stall_cycles,
  output logic [31:0]                       full_cycles,
  output logic [31:0]                       flush_count
`endif
);

  localparam int ENTRY_W = 3 * XLEN;

  // Queue storage and pointers
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_BITS-1:0] count_q, count_d;

  // Per-lane enqueue bookkeeping
  logic [CNT_BITS-1:0] lane_off [SUPERSCALAR_WAYS];
  logic                lane_we  [SUPERSCALAR_WAYS];
  logic [CNT_BITS-1:0] enq;
  logic [CNT_BITS-1:0] deq;

  // Dispatch feedback fields
  logic                stall_en;
  logic [CNT_BITS-1:0] stall_idx;
  logic [CNT_BITS-1:0] ways_c;
  logic [CNT_BITS-1:0] deq_lim;

  assign stall_en  = dispatch_fetch_in[IDX_W];
  assign stall_idx = CNT_BITS'(dispatch_fetch_in[IDX_W-1:0]);
  assign ways_c    = CNT_BITS'(SUPERSCALAR_WAYS);

  // Readiness depends on registered occupancy only, never on this cycle's inputs.
  assign fetch_ready = (CNT_BITS'(DEPTH) - count_q) >= ways_c;
  assign count       = count_q;

  // Compact valid fetch lanes into consecutive slots starting at tail.
  always_comb begin
    // NOTE: enq is an in-process running sum, so blocking '=' is required here;
    // each lane sees the count of valid lanes before it.
    enq = '0;
    for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
      lane_off[i] = enq;
      lane_we[i]  = fetch_ready && !branch_flush_en && fetch_in[i*PKT_W];
      if (lane_we[i]) enq = enq + CNT_BITS'(1);
    end
  end

  // Dequeue count: dispatched prefix, never more than what is present.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    deq_lim = ways_c;
    if (stall_en) deq_lim = (stall_idx < ways_c) ? stall_idx : ways_c;
    deq = (count_q < deq_lim) ? count_q : deq_lim;
  end

  // Next-state for pointers and occupancy; flush overrides enqueue and dequeue.
  always_comb begin
    head_d  = head_q + PTR_W'(deq);
    tail_d  = tail_q + PTR_W'(enq);
    count_d = count_q + enq - deq;
    if (branch_flush_en) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage writes for accepted lanes.
  // NOTE: the entry array is deliberately not reset; a slot is only ever read
  // when count marks it valid, and invalid output lanes are forced to zero.
  always_ff @(posedge clock) begin
    for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
      if (lane_we[i]) begin
        mem_q[tail_q + PTR_W'(lane_off[i])] <= fetch_in[i*PKT_W+1 +: ENTRY_W];
      end
    end
  end

  // Present the oldest entries; lanes beyond the occupancy read as all zero.
  always_comb begin
    dispatch_out = '0;
    for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
      if (CNT_BITS'(i) < count_q) begin
        dispatch_out[i*PKT_W +: PKT_W] = {mem_q[head_q + PTR_W'(i)], 1'b1};
      end
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      full_cycles  <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_en && (count_q != '0) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (!fetch_ready && (full_cycles != '1))
        full_cycles <= full_cycles + 32'd1;
      if (branch_flush_en && (flush_count != '1))
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_dispatch_queue.sv
// Directed self-checking bench for fetch_dispatch_queue (WAYS=3, DEPTH=8).
// Inputs are driven 1 time unit after the rising edge; outputs are checked at
// that same point, reflecting the state registered at that edge.
module tb_fetch_dispatch_queue;

  localparam int WAYS     = 3;
  localparam int DEPTH    = 8;
  localparam int XLEN     = 32;
  localparam int PKT_W    = 3 * XLEN + 1;
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam int IDX_W    = $clog2(WAYS + 1);

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic                    branch_flush_en;
  logic [WAYS*PKT_W-1:0]   fetch_in;
  logic [IDX_W:0]          dispatch_fetch_in;
  logic                    fetch_ready;
  logic [WAYS*PKT_W-1:0]   dispatch_out;
  logic [CNT_BITS-1:0]     count;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0]             stall_cycles;
  logic [31:0]             full_cycles;
  logic [31:0]             flush_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  fetch_dispatch_queue #(
    .SUPERSCALAR_WAYS(WAYS),
    .DEPTH           (DEPTH)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .branch_flush_en  (branch_flush_en),
    .fetch_in         (fetch_in),
    .dispatch_fetch_in(dispatch_fetch_in),
    .fetch_ready      (fetch_ready),
    .dispatch_out     (dispatch_out),
    .count            (count)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .stall_cycles     (stall_cycles),
    .full_cycles      (full_cycles),
    .flush_count      (flush_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_fetch();
    fetch_in = '0;
  endtask

  // inst is tagged with 0xA000_0000 | pc, npc is pc+4.
  task automatic set_lane(input int i, input logic [31:0] pc);
    fetch_in[i*PKT_W +: PKT_W] = {32'hA000_0000 | pc, pc, pc + 32'd4, 1'b1};
  endtask

  task automatic set_ctrl(input logic en, input int idx);
    dispatch_fetch_in = {en, IDX_W'(idx)};
  endtask

  function automatic logic [31:0] lane_pc(input int i);
    return dispatch_out[i*PKT_W+33 +: 32];
  endfunction

  function automatic logic [31:0] lane_npc(input int i);
    return dispatch_out[i*PKT_W+1 +: 32];
  endfunction

  function automatic logic [31:0] lane_inst(input int i);
    return dispatch_out[i*PKT_W+65 +: 32];
  endfunction

  function automatic logic [2:0] valids();
    return {dispatch_out[2*PKT_W], dispatch_out[PKT_W], dispatch_out[0]};
  endfunction

  initial begin
    reset_n           = 1'b0;
    branch_flush_en   = 1'b0;
    fetch_in          = '0;
    dispatch_fetch_in = '0;

    // Reset state, observed while reset is held.
    #2;
    check("rst_count", count, 0);
    check("rst_ready", fetch_ready, 1);
    check("rst_valid", valids(), 3'b000);
    check("rst_out_zero", |dispatch_out, 0);

    @(negedge clock);
    reset_n = 1'b1;

    // Fill with 3 instructions, no stall.
    set_lane(0, 32'h0); set_lane(1, 32'h4); set_lane(2, 32'h8);
    set_ctrl(1'b0, 0);
    step();
    check("fill_count", count, 3);
    check("fill_valid", valids(), 3'b111);
    check("fill_pc0", lane_pc(0), 32'h0);
    check("fill_pc1", lane_pc(1), 32'h4);
    check("fill_pc2", lane_pc(2), 32'h8);
    check("fill_inst1", lane_inst(1), 32'hA000_0004);
    clear_fetch();
    step();
    check("drain_count", count, 0);
    check("drain_valid", valids(), 3'b000);

    // Partial stall.
    set_lane(0, 32'h20); set_lane(1, 32'h24); set_lane(2, 32'h28);
    set_ctrl(1'b1, 0);
    step();
    check("pst_fill_count", count, 3);
    clear_fetch();
    set_ctrl(1'b1, 1);
    step();
    check("pst1_count", count, 2);
    check("pst1_pc0", lane_pc(0), 32'h24);
    check("pst1_pc1", lane_pc(1), 32'h28);
    check("pst1_valid", valids(), 3'b011);
    set_ctrl(1'b1, 0);
    step();
    check("pst0_count", count, 2);
    check("pst0_pc0", lane_pc(0), 32'h24);
    set_ctrl(1'b0, 0);
    step();
    check("pst_drain_count", count, 0);

    // Wrap: head is now 6; enqueue 3 and dequeue 3 per cycle.
    for (int c = 0; c < 4; c++) begin
      set_lane(0, 32'h100 + 32'(12 * c));
      set_lane(1, 32'h104 + 32'(12 * c));
      set_lane(2, 32'h108 + 32'(12 * c));
      step();
      check($sformatf("wrap%0d_count", c), count, 3);
      check($sformatf("wrap%0d_pc0", c), lane_pc(0), 32'h100 + 32'(12 * c));
      check($sformatf("wrap%0d_pc1", c), lane_pc(1), 32'h104 + 32'(12 * c));
      check($sformatf("wrap%0d_pc2", c), lane_pc(2), 32'h108 + 32'(12 * c));
    end
    clear_fetch();
    step();
    check("wrap_drain_count", count, 0);

    // Full backpressure: stall everything, enqueue 3 per cycle.
    set_ctrl(1'b1, 0);
    set_lane(0, 32'h200); set_lane(1, 32'h204); set_lane(2, 32'h208);
    step();
    check("full3_count", count, 3);
    check("full3_ready", fetch_ready, 1);
    set_lane(0, 32'h20C); set_lane(1, 32'h210); set_lane(2, 32'h214);
    step();
    check("full6_count", count, 6);
    check("full6_ready", fetch_ready, 0);
    set_lane(0, 32'h218); set_lane(1, 32'h21C); set_lane(2, 32'h220);
    step();
    check("full_drop_count", count, 6);
    check("full_drop_ready", fetch_ready, 0);
    check("full_drop_pc0", lane_pc(0), 32'h200);

    // Flush with a simultaneous enqueue at count 5.
    clear_fetch();
    set_ctrl(1'b1, 1);
    step();
    check("pre_flush_count", count, 5);
    check("pre_flush_pc0", lane_pc(0), 32'h204);
    check("pre_flush_ready", fetch_ready, 1);
    set_lane(0, 32'h300); set_lane(1, 32'h304); set_lane(2, 32'h308);
    set_ctrl(1'b0, 0);
    branch_flush_en = 1'b1;
    step();
    branch_flush_en = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", valids(), 3'b000);
    check("flush_ready", fetch_ready, 1);
    check("flush_out_zero", |dispatch_out, 0);

    // Sparse lanes: valid = 101.
    clear_fetch();
    set_lane(0, 32'h10);
    set_lane(2, 32'h18);
    step();
    check("sparse_count", count, 2);
    check("sparse_valid", valids(), 3'b011);
    check("sparse_pc0", lane_pc(0), 32'h10);
    check("sparse_pc1", lane_pc(1), 32'h18);
    check("sparse_npc1", lane_npc(1), 32'h1C);
    check("sparse_pc2_zero", lane_pc(2), 32'h0);

    // Asynchronous reset mid-operation, between clock edges.
    clear_fetch();
    set_ctrl(1'b1, 0);
    step();
    check("hold_count", count, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_valid", valids(), 3'b000);
    check("async_rst_ready", fetch_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
